// File: rtl/data_mov_pkg.sv
// Shared constants for the data-move unit: opcodes, error codes, FSM states.
package data_mov_pkg;

    localparam logic [4:0] LDW = 5'b00001;
    localparam logic [4:0] STW = 5'b00010;
    localparam logic [4:0] MV  = 5'b00011;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ILL   = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

endpackage

// File: rtl/data_mov_agen.sv
// Effective address generator: base + sign-extended offset, plus word alignment check.
module data_mov_agen #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [IMM_W-1:0]  imm,
    input  logic              has_imm,
    output logic [ADDR_W-1:0] ea,
    output logic              misaligned
);

    localparam int ALIGN_W = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] imm_ext;

    // Sign-extend the offset and add; wrap modulo 2^ADDR_W.
    always_comb begin
        imm_ext    = ADDR_W'($signed(imm));
        ea         = has_imm ? base + imm_ext : base;
        misaligned = |ea[ALIGN_W-1:0];
    end

endmodule

// File: rtl/data_mov_unit.sv
// Multi-cycle MV / LDW / STW executor with req/ack memory port and timeout.
module data_mov_unit
    import data_mov_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int IMM_W   = 16,
    parameter int RIDX_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic              has_imm,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] x,
    input  logic [RIDX_W-1:0] rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [RIDX_W-1:0] wb_idx,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic [1:0]        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ea;
    logic              misaligned;
    logic [DATA_W-1:0] imm_data;

    data_mov_agen #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_agen (
        .base       (base),
        .imm        (imm),
        .has_imm    (has_imm),
        .ea         (ea),
        .misaligned (misaligned)
    );

    // Sign-extended immediate used as the MV source operand.
    always_comb begin
        imm_data = DATA_W'($signed(imm));
    end

    // Outputs decoded from state so reset drops mem_req asynchronously.
    always_comb begin
        in_ready = (state == S_IDLE);
        mem_req  = (state == S_MEM);
        wb_valid = (state == S_WB);
        done     = (state == S_WB) || (state == S_FIN);
    end

    // Instruction FSM, memory-port registers, timeout counter and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            err       <= ERR_OK;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_idx    <= '0;
            wb_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        wb_idx <= rd;
                        case (opcode)
                            MV: begin
                                wb_data <= has_imm ? imm_data : x;
                                err     <= ERR_OK;
                                state   <= S_WB;
                            end
                            LDW, STW: begin
                                if (misaligned) begin
                                    err   <= ERR_ALIGN;
                                    state <= S_FIN;
                                end else begin
                                    mem_addr  <= ea;
                                    mem_we    <= (opcode == STW);
                                    mem_wdata <= x;
                                    cnt       <= '0;
                                    state     <= S_MEM;
                                end
                            end
                            default: begin
                                err   <= ERR_ILL;
                                state <= S_FIN;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    // An ack in the final allowed cycle takes priority over the timeout.
                    if (mem_ack) begin
                        err <= ERR_OK;
                        if (mem_we) begin
                            state <= S_FIN;
                        end else begin
                            wb_data <= mem_rdata;
                            state   <= S_WB;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == TMO_LAST) begin
                            err   <= ERR_TMO;
                            state <= S_FIN;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mov_unit.sv
// Directed self-checking bench for data_mov_unit.
module tb_data_mov_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic        has_imm;
    logic [15:0] imm;
    logic [31:0] base;
    logic [31:0] x;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        done;
    logic [1:0]  err;

    int n_chk = 0;
    int n_bad = 0;

    data_mov_unit #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .IMM_W   (16),
        .RIDX_W  (5),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .has_imm   (has_imm),
        .imm       (imm),
        .base      (base),
        .x         (x),
        .rd        (rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction; returns just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic hi, input logic [15:0] im,
                         input logic [31:0] b, input logic [31:0] xv, input logic [4:0] r);
        @(negedge clk);
        opcode   = op;
        has_imm  = hi;
        imm      = im;
        base     = b;
        x        = xv;
        rd       = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 5'b00000;
        base     = 32'hFFFF_FFFF;
    endtask

    initial begin
        int n_req;
        bit saw_done;
        bit saw_wb;

        rst = 1'b1; in_valid = 1'b0; opcode = '0; has_imm = 1'b0; imm = '0;
        base = '0; x = '0; rd = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // 1. MV immediate
        issue(5'b00011, 1'b1, 16'hFFFE, 32'h0, 32'h0, 5'd3);
        @(negedge clk);
        chk("mv_wb_valid", wb_valid, 1);
        chk("mv_wb_idx", wb_idx, 3);
        chk("mv_wb_data", wb_data, 32'hFFFF_FFFE);
        chk("mv_done", done, 1);
        chk("mv_err", err, 0);
        chk("mv_in_ready_busy", in_ready, 0);
        @(negedge clk);
        chk("mv_done_clear", done, 0);
        chk("mv_in_ready", in_ready, 1);

        // MV register source
        issue(5'b00011, 1'b0, 16'hFFFF, 32'h0, 32'hA5A5_0001, 5'd7);
        @(negedge clk);
        chk("mvx_wb_data", wb_data, 32'hA5A5_0001);
        chk("mvx_wb_idx", wb_idx, 7);

        // 2. LDW with 3 wait cycles
        issue(5'b00001, 1'b1, 16'h0008, 32'h100, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ldw_req_wait", mem_req, 1);
            chk("ldw_addr", mem_addr, 32'h108);
            chk("ldw_we", mem_we, 0);
        end
        @(negedge clk);
        chk("ldw_req_ack", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("ldw_wb_valid", wb_valid, 1);
        chk("ldw_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("ldw_wb_idx", wb_idx, 9);
        chk("ldw_done", done, 1);
        chk("ldw_err", err, 0);
        chk("ldw_req_drop", mem_req, 0);

        // 3. STW negative offset, immediate ack
        issue(5'b00010, 1'b1, 16'hFFFC, 32'h200, 32'h1234_5678, 5'd1);
        @(negedge clk);
        chk("stw_req", mem_req, 1);
        chk("stw_addr", mem_addr, 32'h1FC);
        chk("stw_we", mem_we, 1);
        chk("stw_wdata", mem_wdata, 32'h1234_5678);
        chk("stw_done_early", done, 0);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stw_done", done, 1);
        chk("stw_wb_valid", wb_valid, 0);
        chk("stw_err", err, 0);
        chk("stw_req_drop", mem_req, 0);

        // 4. Misaligned LDW
        issue(5'b00001, 1'b0, 16'h0, 32'h101, 32'h0, 5'd2);
        @(negedge clk);
        chk("mis_req", mem_req, 0);
        chk("mis_done", done, 1);
        chk("mis_err", err, 2);
        chk("mis_wb_valid", wb_valid, 0);
        @(negedge clk);
        chk("mis_err_hold", err, 2);

        // 5a. Timeout with no ack
        issue(5'b00001, 1'b1, 16'h0, 32'h40, 32'h0, 5'd4);
        n_req = 0; saw_done = 1'b0; saw_wb = 1'b0;
        for (int i = 0; i < 40 && !saw_done; i++) begin
            @(negedge clk);
            if (mem_req) n_req++;
            if (wb_valid) saw_wb = 1'b1;
            if (done) saw_done = 1'b1;
        end
        chk("tmo_done_seen", saw_done, 1);
        chk("tmo_req_cycles", n_req, 15);
        chk("tmo_err", err, 3);
        chk("tmo_no_wb", saw_wb, 0);
        @(negedge clk);
        chk("tmo_err_hold", err, 3);
        chk("tmo_done_clear", done, 0);

        // 5b. Ack arrives in the timeout cycle
        issue(5'b00001, 1'b1, 16'h0, 32'h40, 32'h0, 5'd5);
        n_req = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (mem_req) n_req++;
        end
        chk("tmoack_req_cycles", n_req, 15);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("tmoack_err", err, 0);
        chk("tmoack_wb_valid", wb_valid, 1);
        chk("tmoack_wb_data", wb_data, 32'hCAFE_F00D);

        // 6. Illegal opcode
        issue(5'b11111, 1'b1, 16'h0004, 32'h100, 32'h0, 5'd6);
        @(negedge clk);
        chk("ill_done", done, 1);
        chk("ill_err", err, 1);
        chk("ill_wb_valid", wb_valid, 0);
        chk("ill_req", mem_req, 0);

        // Reset mid-MEM
        issue(5'b00001, 1'b1, 16'h0, 32'h80, 32'h0, 5'd8);
        @(negedge clk);
        chk("rstmem_req_before", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmem_req_async", mem_req, 0);
        chk("rstmem_in_ready", in_ready, 1);
        chk("rstmem_done", done, 0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || wb_valid) saw_done = 1'b1;
        end
        chk("rstmem_no_pulse", saw_done, 0);
        chk("rstmem_idle", in_ready, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
